// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory answering CPU fetch/load/store requests with fixed latency.
// Define MEM_RESPONDER_WAIT_EN to build the WAIT state and WAIT_CYCLES wait-state counter.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_params
        $error("mem_responder: WAIT_CYCLES must be 1..15 and ADDR_WIDTH 1..29");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                ready_d;
    logic                access_c;
    logic                acc_write_c;
    logic [DATA_W-1:0]   acc_addr_c;
    logic [DATA_W-1:0]   acc_wdata_c;
    logic                acc_err_c;
    logic [ADDR_WIDTH-1:0] acc_idx_c;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_RESPONDER_WAIT_EN
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              hold_write;
    logic [DATA_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    // Request is latched at acceptance and performed when the wait count expires
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && req_valid) begin
            hold_write <= req_write;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign acc_write_c = hold_write;
    assign acc_addr_c  = hold_addr;
    assign acc_wdata_c = hold_wdata;
`else
    // Without wait states the access happens on the acceptance edge itself
    assign acc_write_c = req_write;
    assign acc_addr_c  = req_addr;
    assign acc_wdata_c = req_wdata;
`endif

    assign acc_err_c = (acc_addr_c[1:0] != 2'b00) || (|acc_addr_c[DATA_W-1:ADDR_WIDTH+2]);
    assign acc_idx_c = acc_addr_c[ADDR_WIDTH+1:2];

    always_comb begin
        state_d  = state_q;
        ready_d  = req_ready;
        access_c = 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ready_d = 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
`else
                    state_d  = ST_RESP;
                    access_c = 1'b1;
`endif
                end
            end
`ifdef MEM_RESPONDER_WAIT_EN
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_RESP;
                    access_c = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Response data reads the word before any same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_ready  <= ready_d;
            resp_valid <= access_c;
            if (access_c) begin
                resp_err   <= acc_err_c;
                resp_rdata <= (acc_err_c || acc_write_c) ? '0 : mem[acc_idx_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (access_c && !acc_err_c && acc_write_c) begin
            mem[acc_idx_c] <= acc_wdata_c;
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data/instruction memory that answers the multicycle CPU's fetch, load and store requests over a valid/ready request channel and a single-cycle response pulse. It sits on the memory side of the datapath. Each request is accepted once, held for a fixed number of wait states, and then committed or read, so the control FSM's IF and MEM states see realistic memory latency. Misaligned or out-of-range accesses are flagged rather than silently aliased.

## Interface
- ADDR_WIDTH, 10: word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2: wait states per access, legal range 1..15. Active only with the configuration macro.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load/fetch.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; 0 on stores and errors.
- resp_err  output  1  access rejected; qualified by resp_valid.

## Operation
- States: IDLE, WAIT, RESP. State is encoded in 2 bits. The wait counter is 4 bits.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, capture req_write, req_addr and req_wdata into holding registers.
  - Load the counter with WAIT_CYCLES and go to WAIT.
  - With req_valid=0, stay in IDLE.
- WAIT:
  - req_ready=0, and request inputs are ignored.
  - The counter decrements each edge. When counter==1, go to RESP on that edge.
  - The access is performed on that same edge.
- Access, on entry to RESP:
  - An error occurs when addr[1:0]!=0 or addr[31:2] >= 2**ADDR_WIDTH. On error: resp_err=1, resp_rdata=0, and memory is unchanged.
  - A valid store writes wdata to word addr[ADDR_WIDTH+1:2]. resp_rdata=0.
  - A valid load sets resp_rdata to the stored word, which is the contents before any same-edge write.
- RESP:
  - resp_valid=1 for exactly one cycle. req_ready=0.
  - Unconditionally return to IDLE. There is no response backpressure.
- resp_rdata and resp_err hold their values until the next RESP entry.
- Simultaneous events: a request presented during WAIT or RESP is not accepted. The requester must hold req_valid until it sees req_ready=1 at an edge.
- Memory array contents are not reset and start undefined.

## Timing
- All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, counter=0.
- Reset mid-operation returns to IDLE immediately. Any uncommitted store is discarded, and no resp_valid is produced for that request.
- Latency (macro defined):
  - Acceptance edge at cycle 0.
  - resp_valid is high during cycle WAIT_CYCLES+1 after the acceptance edge.
  - req_ready returns high one cycle later.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- A store is visible to a load accepted at any later edge.

## Configuration
- MEM_RESPONDER_WAIT_EN defined:
  - The WAIT state and wait counter are built.
  - Latency is WAIT_CYCLES+1.
- MEM_RESPONDER_WAIT_EN undefined:
  - The WAIT state and counter are removed, and WAIT_CYCLES is ignored.
  - IDLE goes to RESP directly on the acceptance edge, and the access is performed on that edge.
  - resp_valid is high the cycle after acceptance, giving latency 1 and throughput one access per 2 cycles.
- All other behaviour is identical in both builds.

## Test plan
- Reset: drive rst_n low during a WAIT carrying a store of 0xDEADBEEF to 0x10, then release it.
  - Required: outputs go to their reset values, no resp_valid appears, and a later load from 0x10 does not return 0xDEADBEEF (preload the word with 0x0).
- Store then load, WAIT_CYCLES=2, macro defined:
  - Store 0x12345678 to 0x004. Required: resp_valid exactly 3 cycles after acceptance, resp_err=0, resp_rdata=0.
  - Load 0x004. Required: resp_rdata=0x12345678.
- Misaligned access: load 0x006. Required: resp_err=1, resp_rdata=0.
- Out-of-range access: store 0xFFFF to 0x1000 with ADDR_WIDTH=10. Required: resp_err=1, and a load of 0x000 is unchanged.
- Back-to-back: req_valid held high across three loads at 0x0, 0x4 and 0x8.
  - Required: acceptances exactly 4 cycles apart.
  - Required: req_ready=0 in every WAIT and RESP cycle.
  - Required: no request lost or duplicated.
- Macro undefined: store 0xA5A5A5A5 to 0x3FC, then load 0x3FC.
  - Required: each resp_valid arrives 1 cycle after acceptance, and the load returns 0xA5A5A5A5.
